instr_fetch_decode: RTL and testbench

//  Front-end stage of the 8-bit microprocessor. Fetches one 8-bit instruction per

---
 rtl/instr_fetch_decode_pkg.sv | 49 ++++
 rtl/instr_fetch_decode_if.sv | 35 +++
 rtl/instr_fetch_decode.sv | 105 ++++++++++
 tb/tb_instr_fetch_decode.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_decode_pkg.sv
// Shared definitions for the fetch/decode front end: opcodes, instruction field
// positions, FSM state encodings and small decode helpers.
package instr_fetch_decode_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_JMP = 2'b11;

  localparam int unsigned OP_MSB  = 7;
  localparam int unsigned OP_LSB  = 6;
  localparam int unsigned RS_MSB  = 5;
  localparam int unsigned RS_LSB  = 4;
  localparam int unsigned RT_MSB  = 3;
  localparam int unsigned RT_LSB  = 2;
  localparam int unsigned RD_MSB  = 1;
  localparam int unsigned RD_LSB  = 0;
  localparam int unsigned IMM_MSB = 1;
  localparam int unsigned IMM_LSB = 0;
  // Width of the in-page jump offset carried in a JMP instruction.
  localparam int unsigned JMP_OFFSET_WIDTH = 6;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;

  typedef struct packed {
    logic [1:0] op;
    logic [1:0] rs;
    logic [1:0] rt;
    logic [1:0] rd;
    logic [1:0] imm;
  } dec_fields_t;

  function automatic dec_fields_t split_instr(input logic [7:0] instr);
    dec_fields_t f;
    f.op  = instr[OP_MSB:OP_LSB];
    f.rs  = instr[RS_MSB:RS_LSB];
    f.rt  = instr[RT_MSB:RT_LSB];
    f.rd  = instr[RD_MSB:RD_LSB];
    f.imm = instr[IMM_MSB:IMM_LSB];
    return f;
  endfunction

  function automatic logic is_jump(input logic [7:0] instr);
    return instr[OP_MSB:OP_LSB] == OP_JMP;
  endfunction

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Instruction-memory request bus and decoded-instruction handshake of the front end.
// master = the fetch/decode stage, slave = memory plus execute stage.
interface instr_fetch_decode_if #(
  parameter int unsigned PC_WIDTH    = 8,
  parameter int unsigned INSTR_WIDTH = 8
);

  logic                   imem_req;
  logic [PC_WIDTH-1:0]    imem_addr;
  logic                   imem_ack;
  logic [INSTR_WIDTH-1:0] imem_rdata;

  logic                   dec_valid;
  logic                   ex_ready;
  logic [1:0]             dec_op;
  logic [1:0]             dec_rs;
  logic [1:0]             dec_rt;
  logic [1:0]             dec_rd;
  logic [1:0]             dec_imm;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    output dec_valid, dec_op, dec_rs, dec_rt, dec_rd, dec_imm,
    input  ex_ready
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    input  dec_valid, dec_op, dec_rs, dec_rt, dec_rd, dec_imm,
    output ex_ready
  );

endinterface

// File: rtl/instr_fetch_decode.sv
// Front-end stage: fetches one instruction per request into the IR, presents its
// fields to execute with valid/ready, and resolves JMP locally.
module instr_fetch_decode
  import instr_fetch_decode_pkg::*;
#(
  parameter int unsigned         PC_WIDTH    = 8,
  parameter int unsigned         INSTR_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                clk,
  input  logic                reset_n,
  instr_fetch_decode_if.master bus,
  output logic [PC_WIDTH-1:0] pc,
  output logic [7:0]          instr_count
);

  logic [1:0]             state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic                   req_q, req_d;
  logic                   valid_q, valid_d;
  logic [7:0]             count_q, count_d;
  logic                   fetch_done;
  logic                   transfer;
  dec_fields_t            fields;

  // A late ack with no request outstanding (e.g. right after reset) is ignored.
  assign fetch_done = req_q & bus.imem_ack;
  assign transfer   = valid_q & bus.ex_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    req_d   = req_q;
    valid_d = valid_q;
    count_d = count_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        req_d   = 1'b1;
      end
      S_FETCH: begin
        if (fetch_done) begin
          ir_d    = bus.imem_rdata;
          pc_d    = pc_q + PC_WIDTH'(1);
          req_d   = 1'b0;
          valid_d = ~is_jump(bus.imem_rdata);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_jump(ir_q)) begin
          // pc already points past the JMP, so its page bits come from pc+1.
          pc_d    = {pc_q[PC_WIDTH-1:JMP_OFFSET_WIDTH], ir_q[JMP_OFFSET_WIDTH-1:0]};
          count_d = count_q + 8'd1;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end else if (transfer) begin
          valid_d = 1'b0;
          count_d = count_q + 8'd1;
          req_d   = 1'b1;
          state_d = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign fields = split_instr(ir_q);

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = pc_q;
  assign bus.dec_valid = valid_q;
  assign bus.dec_op    = fields.op;
  assign bus.dec_rs    = fields.rs;
  assign bus.dec_rt    = fields.rt;
  assign bus.dec_rd    = fields.rd;
  assign bus.dec_imm   = fields.imm;
  assign pc            = pc_q;
  assign instr_count   = count_q;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed bench for instr_fetch_decode: reset, handshake, stall, jumps, PC wrap,
// and reset while a fetch is outstanding.
module tb_instr_fetch_decode;

  logic       clk;
  logic       reset_n;
  logic [7:0] pc;
  logic [7:0] instr_count;
  int         n_checks;
  int         n_pass;
  logic [7:0] exp_count;

  instr_fetch_decode_if #(.PC_WIDTH(8), .INSTR_WIDTH(8)) bus ();

  instr_fetch_decode #(
    .PC_WIDTH   (8),
    .INSTR_WIDTH(8),
    .RESET_PC   (8'h00)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .pc         (pc),
    .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full fetch/decode of ins at address addr with execute always ready.
  task automatic run_instr(input logic [7:0] ins, input logic [7:0] addr,
                           input logic [7:0] next_addr, input logic is_jmp);
    check("run_req", 32'(bus.imem_req), 32'd1);
    check("run_addr", 32'(bus.imem_addr), 32'(addr));
    bus.imem_rdata = ins;
    bus.imem_ack   = 1'b1;
    bus.ex_ready   = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("run_valid", 32'(bus.dec_valid), is_jmp ? 32'd0 : 32'd1);
    check("run_req_low", 32'(bus.imem_req), 32'd0);
    step();
    exp_count = exp_count + 8'd1;
    check("run_next_addr", 32'(bus.imem_addr), 32'(next_addr));
    check("run_count", 32'(instr_count), 32'(exp_count));
  endtask

  initial begin
    n_checks       = 0;
    n_pass         = 0;
    exp_count      = 8'd0;
    reset_n        = 1'b0;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 8'h00;
    bus.ex_ready   = 1'b0;

    // 1: reset and start-up
    repeat (3) step();
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.dec_valid), 32'd0);
    check("rst_op", 32'(bus.dec_op), 32'd0);
    check("rst_rd", 32'(bus.dec_rd), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    check("rst_pc", 32'(pc), 32'd0);
    reset_n = 1'b1;
    check("idle_req", 32'(bus.imem_req), 32'd0);
    step();
    check("fetch_req", 32'(bus.imem_req), 32'd1);
    check("fetch_addr", 32'(bus.imem_addr), 32'h00);
    check("fetch_dec_rs", 32'(bus.dec_rs), 32'd0);
    check("fetch_count", 32'(instr_count), 32'd0);

    // ex_ready without valid and no ack: nothing moves
    bus.ex_ready = 1'b1;
    step();
    check("noack_req", 32'(bus.imem_req), 32'd1);
    check("noack_addr", 32'(bus.imem_addr), 32'h00);
    check("noack_count", 32'(instr_count), 32'd0);

    // 2: ADD with immediate acceptance
    bus.imem_rdata = 8'b00_01_10_11;
    bus.imem_ack   = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    check("t2_valid", 32'(bus.dec_valid), 32'd1);
    check("t2_op", 32'(bus.dec_op), 32'd0);
    check("t2_rs", 32'(bus.dec_rs), 32'd1);
    check("t2_rt", 32'(bus.dec_rt), 32'd2);
    check("t2_rd", 32'(bus.dec_rd), 32'd3);
    check("t2_imm", 32'(bus.dec_imm), 32'd3);
    check("t2_pc", 32'(pc), 32'h01);
    step();
    check("t2_valid_drop", 32'(bus.dec_valid), 32'd0);
    check("t2_addr", 32'(bus.imem_addr), 32'h01);
    check("t2_count", 32'(instr_count), 32'd1);

    // 3: execute stalls for 3 cycles
    bus.ex_ready = 1'b0;
    bus.imem_ack = 1'b1;
    step();
    bus.imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_valid", 32'(bus.dec_valid), 32'd1);
      check("t3_hold_rt", 32'(bus.dec_rt), 32'd2);
      check("t3_hold_req", 32'(bus.imem_req), 32'd0);
      check("t3_hold_count", 32'(instr_count), 32'd1);
    end
    bus.ex_ready = 1'b1;
    step();
    check("t3_valid_drop", 32'(bus.dec_valid), 32'd0);
    check("t3_count", 32'(instr_count), 32'd2);
    check("t3_addr", 32'(bus.imem_addr), 32'h02);
    exp_count = 8'd2;

    // walk to pc=41
    run_instr(8'hFF, 8'h02, 8'h3F, 1'b1);
    run_instr(8'h00, 8'h3F, 8'h40, 1'b0);
    run_instr(8'h00, 8'h40, 8'h41, 1'b0);
    // 4: JMP at 41 stays in page 01
    run_instr(8'b11_000101, 8'h41, 8'h45, 1'b1);

    // walk to pc=FF
    run_instr(8'hFF, 8'h45, 8'h7F, 1'b1);
    run_instr(8'h00, 8'h7F, 8'h80, 1'b0);
    run_instr(8'hFF, 8'h80, 8'hBF, 1'b1);
    run_instr(8'h00, 8'hBF, 8'hC0, 1'b0);
    run_instr(8'hFF, 8'hC0, 8'hFF, 1'b1);
    // 5a: ADD at FF wraps to 00
    run_instr(8'b00_11_01_10, 8'hFF, 8'h00, 1'b0);
    check("t5_rs", 32'(bus.dec_rs), 32'd3);
    run_instr(8'hFF, 8'h00, 8'h3F, 1'b1);
    run_instr(8'h00, 8'h3F, 8'h40, 1'b0);
    run_instr(8'hFF, 8'h40, 8'h7F, 1'b1);
    run_instr(8'h00, 8'h7F, 8'h80, 1'b0);
    run_instr(8'hFF, 8'h80, 8'hBF, 1'b1);
    run_instr(8'h00, 8'hBF, 8'hC0, 1'b0);
    run_instr(8'hFF, 8'hC0, 8'hFF, 1'b1);
    // 5b: JMP at FF targets page 00
    run_instr(8'b11_001010, 8'hFF, 8'h0A, 1'b1);
    check("t5_count", 32'(instr_count), 32'd20);

    // 6: reset while a fetch is outstanding, late ack during reset
    check("t6_req_before", 32'(bus.imem_req), 32'd1);
    reset_n = 1'b0;
    #1;
    check("t6_req", 32'(bus.imem_req), 32'd0);
    check("t6_pc", 32'(pc), 32'h00);
    check("t6_count", 32'(instr_count), 32'd0);
    check("t6_valid", 32'(bus.dec_valid), 32'd0);
    bus.imem_rdata = 8'hC3;
    bus.imem_ack   = 1'b1;
    step();
    check("t6_ir_op", 32'(bus.dec_op), 32'd0);
    check("t6_ir_rd", 32'(bus.dec_rd), 32'd0);
    bus.imem_ack = 1'b0;
    reset_n      = 1'b1;
    step();
    check("t6_restart_req", 32'(bus.imem_req), 32'd1);
    check("t6_restart_addr", 32'(bus.imem_addr), 32'h00);
    exp_count = 8'd0;
    run_instr(8'b10_00_01_01, 8'h00, 8'h01, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
